// File: rtl/hw_int_ctrl.sv
// -----------------------------------------------------------------------------
// hw_int_ctrl -- interrupt aggregator with a built-in compare timer.
//
// Collects seven asynchronous external interrupt lines (irq_src[6:0]) plus
// one internal timer interrupt into an 8-bit pending register. The masked
// pending bits drive hw_int, which feeds the CPU's hardware interrupt
// inputs. Software reaches the block through a data-SRAM style register port.
//
// Ports
//   clk      in   1   sole clock, all flops on the rising edge
//   reset    in   1   asynchronous, active-high reset
//   en       in   1   register-port access strobe
//   we       in   4   byte write enables, 4'b0000 means read
//   addr     in  32   byte address, only addr[4:2] is decoded
//   wdata    in  32   write data
//   rdata    out 32   read data, valid the cycle after a read access
//   irq_src  in   7   asynchronous external interrupt sources 0..6
//   hw_int   out  8   interrupt lines to the CPU, bit 7 is the timer
//
// Register map (offset = addr[4:2]*4)
//   0x00 PEND[7:0]  R/W1C   level bits ignore W1C, bit 7 is the timer
//   0x04 MASK[7:0]  RW
//   0x08 EDGE[7:0]  RW      bit 7 reads 1 and ignores writes
//   0x0C TCFG[1:0]  RW      bit0 = enable, bit1 = periodic
//   0x10 TCMP[31:0] RW
//   0x14 TCNT[31:0] RW
//   0x18, 0x1C      read 0, writes ignored
//
// Access protocol: there is no back-pressure. Every cycle with en=1 is one
// complete access; we!=0 writes the selected byte lanes at that rising edge,
// we==0 reads and the value appears on rdata after that same edge and holds
// until the next read.
// -----------------------------------------------------------------------------
module hw_int_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [6:0]  irq_src,
    output logic [7:0]  hw_int
);

    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_EDGE = 3'd2;
    localparam logic [2:0] A_TCFG = 3'd3;
    localparam logic [2:0] A_TCMP = 3'd4;
    localparam logic [2:0] A_TCNT = 3'd5;

    // Merge write data into an existing word, one byte lane per enable bit.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [6:0]  sync1_q, sync2_q;   // two-flop synchronizer per source
    logic [6:0]  prev_q;             // previous synced level, for edge detect
    logic [7:0]  pend_q,  pend_d;
    logic [7:0]  mask_q,  mask_d;
    logic [6:0]  edge_q,  edge_d;    // bit 7 is hard-wired to edge mode
    logic [1:0]  tcfg_q,  tcfg_d;
    logic [31:0] tcmp_q,  tcmp_d;
    logic [31:0] tcnt_q,  tcnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  hw_int_q, hw_int_d;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic [2:0] sel;
    logic       rd_acc;
    logic       wr_acc;

    assign sel    = addr[4:2];
    assign rd_acc = en && (we == 4'b0000);
    assign wr_acc = en && (we != 4'b0000);

    // Only addr[4:2] selects a register; the remaining address bits are
    // deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:5], addr[1:0]};

    logic wr_pend, wr_mask, wr_edge, wr_tcfg, wr_tcmp, wr_tcnt;

    // All 8-bit registers live entirely in byte lane 0.
    assign wr_pend = wr_acc && (sel == A_PEND) && we[0];
    assign wr_mask = wr_acc && (sel == A_MASK) && we[0];
    assign wr_edge = wr_acc && (sel == A_EDGE) && we[0];
    assign wr_tcfg = wr_acc && (sel == A_TCFG) && we[0];
    assign wr_tcmp = wr_acc && (sel == A_TCMP);
    assign wr_tcnt = wr_acc && (sel == A_TCNT);

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic        t_match;
    logic [31:0] tcnt_tmr;
    logic [1:0]  tcfg_tmr;

    // The match is evaluated on the current TCNT, so a software write landing
    // in the same cycle still lets a pre-write match raise PEND[7].
    assign t_match = tcfg_q[0] && (tcnt_q == tcmp_q);

    always_comb begin
        tcnt_tmr = tcnt_q;
        tcfg_tmr = tcfg_q;
        if (tcfg_q[0]) begin
            if (t_match) begin
                tcnt_tmr = 32'd0;
                // One-shot mode disarms itself on the match.
                if (!tcfg_q[1]) tcfg_tmr[0] = 1'b0;
            end else begin
                tcnt_tmr = tcnt_q + 32'd1;   // wraps modulo 2^32
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [6:0] edge_set;
    logic [7:0] w1c;

    assign edge_set = sync2_q & ~prev_q;
    assign w1c      = wr_pend ? wdata[7:0] : 8'h00;

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 7; i++) begin
            if (edge_q[i]) begin
                // Edge mode: a new set wins over a coincident clear.
                pend_d[i] = edge_set[i] | (pend_q[i] & ~w1c[i]);
            end else begin
                // Level mode: pending mirrors the synced line, W1C is moot.
                pend_d[i] = sync2_q[i];
            end
        end
        pend_d[7] = t_match | (pend_q[7] & ~w1c[7]);
    end

    always_comb begin
        mask_d = wr_mask ? wdata[7:0] : mask_q;
        edge_d = wr_edge ? wdata[6:0] : edge_q;
        tcmp_d = wr_tcmp ? merge_bytes(tcmp_q, wdata, we) : tcmp_q;
        // Software writes take precedence over the timer's own update.
        tcnt_d = wr_tcnt ? merge_bytes(tcnt_q, wdata, we) : tcnt_tmr;
        tcfg_d = wr_tcfg ? wdata[1:0] : tcfg_tmr;
    end

    // Read mux works on the pre-edge register values.
    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'd0;
        case (sel)
            A_PEND:  rd_val = {24'd0, pend_q};
            A_MASK:  rd_val = {24'd0, mask_q};
            A_EDGE:  rd_val = {24'd0, 1'b1, edge_q};
            A_TCFG:  rd_val = {30'd0, tcfg_q};
            A_TCMP:  rd_val = tcmp_q;
            A_TCNT:  rd_val = tcnt_q;
            default: rd_val = 32'd0;
        endcase
    end

    always_comb begin
        rdata_d  = rd_acc ? rd_val : rdata_q;
        hw_int_d = pend_q & mask_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            edge_q   <= '0;
            tcfg_q   <= '0;
            tcmp_q   <= '0;
            tcnt_q   <= '0;
            rdata_q  <= '0;
            hw_int_q <= '0;
        end else begin
            sync1_q  <= irq_src;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            tcfg_q   <= tcfg_d;
            tcmp_q   <= tcmp_d;
            tcnt_q   <= tcnt_d;
            rdata_q  <= rdata_d;
            hw_int_q <= hw_int_d;
        end
    end

    assign rdata  = rdata_q;
    assign hw_int = hw_int_q;

endmodule

// File: tb/tb_hw_int_ctrl.sv
module tb_hw_int_ctrl;

    localparam logic [31:0] O_PEND = 32'h00;
    localparam logic [31:0] O_MASK = 32'h04;
    localparam logic [31:0] O_EDGE = 32'h08;
    localparam logic [31:0] O_TCFG = 32'h0C;
    localparam logic [31:0] O_TCMP = 32'h10;
    localparam logic [31:0] O_TCNT = 32'h14;
    localparam logic [31:0] O_R18  = 32'h18;
    localparam logic [31:0] O_R1C  = 32'h1C;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [6:0]  irq_src;
    logic [7:0]  hw_int;

    int checks;
    int errors;

    hw_int_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_src (irq_src),
        .hw_int  (hw_int)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Both tasks start and end at a falling edge; the access lands on the
    // rising edge in between. Upper and low address bits are scrambled to
    // show they do not affect decode.
    task automatic bus_write(input logic [31:0] off, input logic [31:0] data,
                             input logic [3:0] be);
        en    = 1'b1;
        we    = be;
        addr  = 32'h7000_0000 | off;
        wdata = data;
        @(negedge clk);
        en    = 1'b0;
        we    = 4'h0;
        wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] off, output logic [31:0] data);
        en   = 1'b1;
        we   = 4'h0;
        addr = 32'hA5A5_A503 | off;
        @(negedge clk);
        en   = 1'b0;
        data = rdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] offs [6];
        logic [31:0] exps [6];
        offs = '{O_PEND, O_MASK, O_EDGE, O_TCFG, O_TCMP, O_TCNT};
        exps = '{32'h0, 32'hA5, 32'h80, 32'h0, 32'h0, 32'h0};
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0);
        end
        checks++;
        if (hw_int !== 8'h0) begin
            errors++; $display("FAIL reset_hw_int got %h exp %h", hw_int, 8'h0);
        end
        reset = 1'b0;
        // First access immediately after reset release.
        bus_write(O_MASK, 32'h0000_00A5, 4'h1);
        for (int i = 0; i < 6; i++) begin
            bus_read(offs[i], v);
            checks++;
            if (v !== exps[i]) begin
                errors++; $display("FAIL reset_reg[%0d] got %h exp %h", i, v, exps[i]);
            end
        end
        bus_write(O_MASK, 32'h0, 4'hF);
    endtask

    task automatic test_map();
        logic [31:0] v;
        bus_write(O_TCMP, 32'hAABB_CCDD, 4'h4);
        bus_read(O_TCMP, v);
        checks++;
        if (v !== 32'h00BB_0000) begin
            errors++; $display("FAIL be_lane2 got %h exp %h", v, 32'h00BB_0000);
        end
        bus_write(O_TCMP, 32'h1122_3344, 4'h1);
        bus_read(O_TCMP, v);
        checks++;
        if (v !== 32'h00BB_0044) begin
            errors++; $display("FAIL be_lane0 got %h exp %h", v, 32'h00BB_0044);
        end
        bus_write(O_R18, 32'hFFFF_FFFF, 4'hF);
        bus_read(O_R18, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL read_0x18 got %h exp %h", v, 32'h0);
        end
        bus_write(O_R1C, 32'hFFFF_FFFF, 4'hF);
        bus_read(O_R1C, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL read_0x1c got %h exp %h", v, 32'h0);
        end
        bus_write(O_MASK, 32'hFFFF_FFFF, 4'hF);
        bus_read(O_MASK, v);
        checks++;
        if (v !== 32'h0000_00FF) begin
            errors++; $display("FAIL mask_width got %h exp %h", v, 32'hFF);
        end
        bus_write(O_EDGE, 32'h0, 4'hF);
        bus_read(O_EDGE, v);
        checks++;
        if (v !== 32'h0000_0080) begin
            errors++; $display("FAIL edge_bit7 got %h exp %h", v, 32'h80);
        end
        bus_write(O_TCFG, 32'hFFFF_FFFE, 4'hE);
        bus_read(O_TCFG, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL tcfg_lane got %h exp %h", v, 32'h0);
        end
        bus_write(O_MASK, 32'h0, 4'h1);
    endtask

    task automatic test_level();
        logic [31:0] v;
        bus_write(O_MASK, 32'h01, 4'h1);
        irq_src = 7'h01;
        repeat (3) @(negedge clk);
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL level_rise_early got %h exp %h", hw_int, 8'h00);
        end
        @(negedge clk);
        checks++;
        if (hw_int !== 8'h01) begin
            errors++; $display("FAIL level_rise got %h exp %h", hw_int, 8'h01);
        end
        bus_write(O_PEND, 32'h01, 4'h1);
        checks++;
        if (hw_int !== 8'h01) begin
            errors++; $display("FAIL level_w1c_hw got %h exp %h", hw_int, 8'h01);
        end
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h01) begin
            errors++; $display("FAIL level_w1c_pend got %h exp %h", v, 32'h01);
        end
        irq_src = 7'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (hw_int !== 8'h01) begin
            errors++; $display("FAIL level_fall_early got %h exp %h", hw_int, 8'h01);
        end
        @(negedge clk);
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL level_fall got %h exp %h", hw_int, 8'h00);
        end
    endtask

    task automatic test_edge();
        logic [31:0] v;
        bus_write(O_EDGE, 32'h04, 4'h1);
        bus_write(O_MASK, 32'h04, 4'h1);
        irq_src = 7'h04;
        @(negedge clk);
        irq_src = 7'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (hw_int !== 8'h04) begin
            errors++; $display("FAIL edge_hw got %h exp %h", hw_int, 8'h04);
        end
        repeat (4) @(negedge clk);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h04) begin
            errors++; $display("FAIL edge_sticky got %h exp %h", v, 32'h04);
        end
        bus_write(O_PEND, 32'h04, 4'h1);
        checks++;
        if (hw_int !== 8'h04) begin
            errors++; $display("FAIL edge_w1c_hw_lag got %h exp %h", hw_int, 8'h04);
        end
        @(negedge clk);
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL edge_w1c_hw got %h exp %h", hw_int, 8'h00);
        end
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h00) begin
            errors++; $display("FAIL edge_w1c_pend got %h exp %h", v, 32'h00);
        end
        // Pulse timed so the detected edge lands on the W1C edge.
        irq_src = 7'h04;
        @(negedge clk);
        irq_src = 7'h00;
        @(negedge clk);
        bus_write(O_PEND, 32'h04, 4'h1);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h04) begin
            errors++; $display("FAIL edge_set_wins got %h exp %h", v, 32'h04);
        end
        bus_write(O_PEND, 32'h04, 4'h1);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h00) begin
            errors++; $display("FAIL edge_clear2 got %h exp %h", v, 32'h00);
        end
    endtask

    task automatic test_timer_oneshot();
        logic [31:0] v;
        bus_write(O_MASK, 32'h80, 4'h1);
        bus_write(O_TCMP, 32'd3, 4'hF);
        bus_write(O_TCFG, 32'h1, 4'h1);
        repeat (4) @(negedge clk);
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL oneshot_early got %h exp %h", hw_int, 8'h00);
        end
        @(negedge clk);
        checks++;
        if (hw_int !== 8'h80) begin
            errors++; $display("FAIL oneshot_fire got %h exp %h", hw_int, 8'h80);
        end
        bus_read(O_TCFG, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL oneshot_tcfg got %h exp %h", v, 32'h0);
        end
        repeat (5) @(negedge clk);
        bus_read(O_TCNT, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL oneshot_tcnt_hold got %h exp %h", v, 32'h0);
        end
        bus_write(O_PEND, 32'h80, 4'h1);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL oneshot_clear got %h exp %h", v, 32'h0);
        end
    endtask

    task automatic test_timer_periodic();
        logic [31:0] v;
        bus_write(O_TCMP, 32'd0, 4'hF);
        bus_write(O_TCFG, 32'h3, 4'h1);
        // This W1C coincides with a match every cycle, so the set wins.
        bus_write(O_PEND, 32'h80, 4'h1);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h80) begin
            errors++; $display("FAIL periodic_set_wins got %h exp %h", v, 32'h80);
        end
        checks++;
        if (hw_int !== 8'h80) begin
            errors++; $display("FAIL periodic_hw got %h exp %h", hw_int, 8'h80);
        end
        bus_write(O_PEND, 32'h80, 4'h1);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h80) begin
            errors++; $display("FAIL periodic_every_cycle got %h exp %h", v, 32'h80);
        end
        bus_write(O_TCFG, 32'h0, 4'h1);
        bus_write(O_PEND, 32'h80, 4'h1);
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL periodic_stop got %h exp %h", v, 32'h0);
        end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] v;
        logic [31:0] wrap_exp [4];
        wrap_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        bus_write(O_TCMP, 32'd1, 4'hF);
        bus_write(O_TCNT, 32'hFFFF_FFFE, 4'hF);
        bus_write(O_TCFG, 32'h1, 4'h1);
        // Back-to-back reads of TCNT, one per cycle.
        en   = 1'b1;
        we   = 4'h0;
        addr = O_TCNT;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rdata !== wrap_exp[i]) begin
                errors++; $display("FAIL wrap_tcnt[%0d] got %h exp %h", i, rdata, wrap_exp[i]);
            end
        end
        en = 1'b0;
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL wrap_early got %h exp %h", hw_int, 8'h00);
        end
        @(negedge clk);
        checks++;
        if (hw_int !== 8'h80) begin
            errors++; $display("FAIL wrap_fire got %h exp %h", hw_int, 8'h80);
        end
        bus_read(O_TCNT, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL wrap_tcnt_end got %h exp %h", v, 32'h0);
        end
        bus_write(O_PEND, 32'h80, 4'h1);
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        bus_write(O_TCMP, 32'd5, 4'hF);
        bus_write(O_TCFG, 32'h3, 4'h1);
        repeat (8) @(negedge clk);
        checks++;
        if (hw_int !== 8'h80) begin
            errors++; $display("FAIL areset_pre_hw got %h exp %h", hw_int, 8'h80);
        end
        bus_read(O_TCMP, v);
        checks++;
        if (v !== 32'd5) begin
            errors++; $display("FAIL areset_pre_rd got %h exp %h", v, 32'd5);
        end
        // Assert reset between clock edges and look before the next rise.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL areset_hw got %h exp %h", hw_int, 8'h00);
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL areset_rdata got %h exp %h", rdata, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_read(O_TCNT, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL areset_tcnt got %h exp %h", v, 32'h0);
        end
        bus_write(O_MASK, 32'hFF, 4'h1);
        repeat (20) @(negedge clk);
        checks++;
        if (hw_int !== 8'h00) begin
            errors++; $display("FAIL areset_no_irq got %h exp %h", hw_int, 8'h00);
        end
        bus_read(O_PEND, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL areset_pend got %h exp %h", v, 32'h0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        en      = 1'b0;
        we      = 4'h0;
        addr    = 32'h0;
        wdata   = 32'h0;
        irq_src = 7'h00;
        test_reset();
        test_map();
        test_level();
        test_edge();
        test_timer_oneshot();
        test_timer_periodic();
        test_timer_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
